ssm_mult_pipe: RTL and testbench

- Parametrised, pipelined static-segment approximate multiplier for N-bit unsigned mantissas.
- Successor to the fixed 23/16 combinational segmented multiplier.
- Adds generic N/M, an optional rounding correction, a runtime exact/approximate mode and a valid/ready streaming interface.
- Sits in the FP multiplier datapath between mantissa unpack and normalisation.

---
 rtl/ssm_pkg.sv | 29 ++
 rtl/ssm_seg_sel.sv | 54 +++++
 rtl/ssm_mult_pipe.sv | 135 +++++++++++++
 tb/tb_ssm_mult_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssm_pkg.sv
// ssm_pkg: shared definitions for the static-segment approximate multiplier.
//   seg_shift(n, m) : left shift applied to a truncated operand (n - m)
//   prod_w(n)       : full product width (2n)
//   stage_t         : stage-1 pipeline record (valid, mode, approx, segments,
//                     combined shift). Segment fields are sized for the widest
//                     supported operand; a given instance uses the low N bits.
package ssm_pkg;

    localparam int unsigned SSM_MAX_N   = 64;
    localparam int unsigned SSM_SHIFT_W = 8;

    function automatic int unsigned seg_shift(input int unsigned n, input int unsigned m);
        return n - m;
    endfunction

    function automatic int unsigned prod_w(input int unsigned n);
        return 2 * n;
    endfunction

    typedef struct packed {
        logic                   valid;
        logic                   mode;
        logic                   approx;
        logic [SSM_MAX_N-1:0]   seg_a;
        logic [SSM_MAX_N-1:0]   seg_b;
        logic [SSM_SHIFT_W-1:0] shift;
    } stage_t;

endpackage

// File: rtl/ssm_seg_sel.sv
// ssm_seg_sel: combinational segment selection for one operand.
//   x    in  N  operand
//   mode in  1  1 = exact: pass x through unchanged, no shift
//   seg  out N  selected segment (zero-extended) or full operand
//   sh   out    left shift to restore the segment's weight
//   alfa out 1  operand has non-zero bits above the low segment
module ssm_seg_sel
    import ssm_pkg::*;
#(
    parameter int unsigned N     = 23,
    parameter int unsigned M     = 16,
    parameter bit          ROUND = 1'b1
) (
    input  logic [N-1:0]             x,
    input  logic                     mode,
    output logic [N-1:0]             seg,
    output logic [SSM_SHIFT_W-1:0]   sh,
    output logic                     alfa
);

    localparam int unsigned SH = seg_shift(N, M);

    if (SH == 0) begin : g_no_seg
        // Segment covers the whole operand: never truncated.
        always_comb begin
            alfa = 1'b0;
            seg  = x;
            sh   = '0;
        end
    end else begin : g_seg
        logic [M-1:0] hi;
        logic [M-1:0] hi_r;
        logic         rbit;

        always_comb begin
            alfa = |x[N-1:M];
            hi   = x[N-1:SH];
            rbit = ROUND && x[SH-1];
            // Round half up, saturating so the segment never widens.
            hi_r = (rbit && (hi != '1)) ? hi + 1'b1 : hi;
            seg  = '0;
            sh   = '0;
            if (mode) begin
                seg = x;
            end else if (alfa) begin
                seg = N'(hi_r);
                sh  = SSM_SHIFT_W'(SH);
            end else begin
                seg = N'(x[M-1:0]);
            end
        end
    end

endmodule

// File: rtl/ssm_mult_pipe.sv
// ssm_mult_pipe: 3-stage pipelined static-segment approximate multiplier.
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready = pipeline enable
//   mode                0 = approximate SSM, 1 = exact product
//   a, b                N-bit unsigned operands
//   out_valid/out_ready result handshake
//   p                   2N-bit product
//   approx              result came from at least one truncated operand
// All stages advance together when the output is empty or being consumed;
// bubbles are carried, not compressed.
module ssm_mult_pipe
    import ssm_pkg::*;
#(
    parameter int unsigned N     = 23,
    parameter int unsigned M     = 16,
    parameter bit          ROUND = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic           approx
);

    localparam int unsigned PW = prod_w(N);

    logic                   en;

    logic [N-1:0]           seg_a, seg_b;
    logic [SSM_SHIFT_W-1:0] sh_a, sh_b;
    logic                   alfa_a, alfa_b;

    stage_t                 s1_d, s1_q;

    logic [PW-1:0]          prod_d;
    logic                   s2_valid;
    logic                   s2_approx;
    logic [PW-1:0]          s2_prod;
    logic [SSM_SHIFT_W-1:0] s2_shift;

    logic [PW-1:0]          p_d;
    logic                   s3_valid;
    logic [PW-1:0]          p_q;
    logic                   approx_q;

    // Segment fields above bit N-1 are always zero for this instance.
    logic                   unused_seg_hi;

    assign en       = !s3_valid || out_ready;
    assign in_ready = en;

    ssm_seg_sel #(.N(N), .M(M), .ROUND(ROUND)) u_sel_a (
        .x    (a),
        .mode (mode),
        .seg  (seg_a),
        .sh   (sh_a),
        .alfa (alfa_a)
    );

    ssm_seg_sel #(.N(N), .M(M), .ROUND(ROUND)) u_sel_b (
        .x    (b),
        .mode (mode),
        .seg  (seg_b),
        .sh   (sh_b),
        .alfa (alfa_b)
    );

    // Stage 1 record: shift amounts are summed here so stage 2 carries one value.
    always_comb begin
        s1_d                = '0;
        s1_d.valid          = in_valid;
        s1_d.mode           = mode;
        s1_d.approx         = (alfa_a || alfa_b) && !mode;
        s1_d.seg_a[N-1:0]   = seg_a;
        s1_d.seg_b[N-1:0]   = seg_b;
        s1_d.shift          = sh_a + sh_b;
    end

    // Stage 2 multiply: M x M segments or full N x N operands.
    always_comb begin
        if (s1_q.mode) begin
            prod_d = PW'(s1_q.seg_a[N-1:0]) * PW'(s1_q.seg_b[N-1:0]);
        end else begin
            prod_d = PW'(s1_q.seg_a[M-1:0]) * PW'(s1_q.seg_b[M-1:0]);
        end
    end

    assign unused_seg_hi = &{1'b0, s1_q.seg_a, s1_q.seg_b};

    // Stage 3 restore weight; segment product < 2^(2M) so the shift stays in 2N bits.
    assign p_d = s2_prod << s2_shift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_valid  <= 1'b0;
            s2_approx <= 1'b0;
            s2_prod   <= '0;
            s2_shift  <= '0;
            s3_valid  <= 1'b0;
            p_q       <= '0;
            approx_q  <= 1'b0;
        end else if (en) begin
            if (in_valid) begin
                s1_q <= s1_d;
            end else begin
                s1_q.valid <= 1'b0;
            end

            s2_valid <= s1_q.valid;
            if (s1_q.valid) begin
                s2_approx <= s1_q.approx;
                s2_prod   <= prod_d;
                s2_shift  <= s1_q.shift;
            end

            s3_valid <= s2_valid;
            if (s2_valid) begin
                p_q      <= p_d;
                approx_q <= s2_approx;
            end
        end
    end

    assign out_valid = s3_valid;
    assign p         = p_q;
    assign approx    = approx_q;

endmodule

// File: tb/tb_ssm_mult_pipe.sv
// tb_ssm_mult_pipe: directed and randomised checks of ssm_mult_pipe against a
// spec-level arithmetic model. A second instance with ROUND=0 shares all
// inputs and is checked against its own expectation queue.
module tb_ssm_mult_pipe;

    localparam int unsigned TN = 23;
    localparam int unsigned TM = 16;

    typedef struct {
        logic [2*TN-1:0] p;
        logic            ap;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready, in_ready0;
    logic            mode;
    logic [TN-1:0]   a, b;
    logic            out_valid, out_valid0;
    logic            out_ready;
    logic [2*TN-1:0] p, p0;
    logic            approx, approx0;

    int n_vec = 0;
    int n_err = 0;

    exp_t exp_q[$];
    exp_t exp0_q[$];

    logic            ov_seen, ir_seen, ap_seen, acc_seen;
    logic [2*TN-1:0] p_seen, p0_seen;

    ssm_mult_pipe #(.N(TN), .M(TM), .ROUND(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .approx(approx)
    );

    ssm_mult_pipe #(.N(TN), .M(TM), .ROUND(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .mode(mode), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .p(p0), .approx(approx0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void seg_of(input longint unsigned x, input bit rnd,
                                   output longint unsigned s, output int sh);
        if (x < (64'd1 << TM)) begin
            s  = x;
            sh = 0;
        end else begin
            sh = TN - TM;
            s  = x >> sh;
            if (rnd && (((x >> (sh - 1)) & 64'd1) == 64'd1) && (s < (64'd1 << TM) - 1))
                s = s + 1;
        end
    endfunction

    function automatic exp_t model(input logic m, input logic [TN-1:0] xa,
                                   input logic [TN-1:0] xb, input bit rnd);
        longint unsigned va, vb, sa, sb, full;
        int sha, shb;
        exp_t e;
        va = longint'(xa);
        vb = longint'(xb);
        seg_of(va, rnd, sa, sha);
        seg_of(vb, rnd, sb, shb);
        if (m) full = va * vb;
        else   full = (sa * sb) << (sha + shb);
        e.p  = full[2*TN-1:0];
        e.ap = !m && ((va >> TM) != 0 || (vb >> TM) != 0);
        return e;
    endfunction

    function automatic logic [TN-1:0] ra();
        logic [TN-1:0] v;
        v = TN'($urandom);
        return v >> $urandom_range(0, TN - 1);
    endfunction

    task automatic drive(input logic v, input logic m, input logic [TN-1:0] xa, input logic [TN-1:0] xb);
        in_valid = v;
        mode     = m;
        a        = xa;
        b        = xb;
    endtask

    // One clock: observe at the falling edge, score handshakes, advance.
    task automatic step();
        exp_t e, e0;
        @(negedge clk);
        ov_seen  = out_valid;
        ir_seen  = in_ready;
        p_seen   = p;
        p0_seen  = p0;
        ap_seen  = approx;
        acc_seen = rst_n && in_valid && in_ready;
        if (acc_seen) begin
            exp_q.push_back(model(mode, a, b, 1'b1));
            exp0_q.push_back(model(mode, a, b, 1'b0));
        end
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("stale_result", 64'(out_valid), 64'd0);
            end else begin
                e  = exp_q.pop_front();
                e0 = exp0_q.pop_front();
                check("p", 64'(p), 64'(e.p));
                check("approx", 64'(approx), 64'(e.ap));
                check("p_round0", 64'(p0), 64'(e0.p));
                check("ov_round0", 64'(out_valid0), 64'd1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single operation with out_ready held high: checks 3-cycle latency and values.
    task automatic single(input logic m, input logic [TN-1:0] xa, input logic [TN-1:0] xb,
                          input logic [2*TN-1:0] ep, input logic [2*TN-1:0] ep0, input logic eap);
        out_ready = 1'b1;
        drive(1'b1, m, xa, xb);
        step();
        check("lat_c0", 64'(ov_seen), 64'd0);
        drive(1'b0, 1'b0, '0, '0);
        step();
        check("lat_c1", 64'(ov_seen), 64'd0);
        step();
        check("lat_c2", 64'(ov_seen), 64'd0);
        step();
        check("lat_c3", 64'(ov_seen), 64'd1);
        check("p_const", 64'(p_seen), 64'(ep));
        check("p0_const", 64'(p0_seen), 64'(ep0));
        check("approx_const", 64'(ap_seen), 64'(eap));
    endtask

    initial begin
        logic [TN-1:0]   opa[5];
        logic [TN-1:0]   opb[5];
        logic [2*TN-1:0] p_hold;
        int idx, acc, budget, drain;

        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        step();
        check("rst_out_valid", 64'(ov_seen), 64'd0);
        check("rst_p", 64'(p_seen), 64'd0);
        check("rst_approx", 64'(ap_seen), 64'd0);
        check("rst_in_ready", 64'(ir_seen), 64'd1);

        // Directed values
        single(1'b0, 23'd1000, 23'd2000, 46'd2000000, 46'd2000000, 1'b0);
        single(1'b0, 23'h7FFFFF, 23'd1, 46'h7FFF80, 46'h7FFF80, 1'b1);
        single(1'b0, 23'h400000, 23'h400000, 46'h100000000000, 46'h100000000000, 1'b1);
        single(1'b1, 23'h7FFFFF, 23'h7FFFFF, 46'h3FFFFF000001, 46'h3FFFFF000001, 1'b0);
        single(1'b0, 23'd0, 23'h7FFFFF, 46'd0, 46'd0, 1'b1);
        single(1'b0, 23'h400040, 23'd1, 46'h400080, 46'h400000, 1'b1);

        // Back-to-back with a 3-cycle output stall starting in cycle 4
        for (int i = 0; i < 5; i++) begin
            opa[i] = ra() | 23'h010000;
            opb[i] = ra();
        end
        idx    = 0;
        p_hold = '0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            if (idx < 5) drive(1'b1, 1'b0, opa[idx], opb[idx]);
            else         drive(1'b0, 1'b0, '0, '0);
            step();
            if (acc_seen) idx++;
            if (cyc >= 4 && cyc <= 6) check("stall_in_ready", 64'(ir_seen), 64'd0);
            if (cyc == 4) p_hold = p_seen;
            if (cyc == 5 || cyc == 6) check("stall_p_stable", 64'(p_seen), 64'(p_hold));
        end
        check("stall_all_accepted", 64'(idx), 64'd5);
        check("stall_all_emerged", 64'(exp_q.size()), 64'd0);

        // Reset with two operations in flight
        out_ready = 1'b1;
        drive(1'b1, 1'b0, ra(), ra());
        step();
        drive(1'b1, 1'b1, ra(), ra());
        step();
        drive(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
        exp0_q.delete();
        step();
        check("midrst_out_valid", 64'(ov_seen), 64'd0);
        check("midrst_p", 64'(p_seen), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("midrst_no_stale", 64'(ov_seen), 64'd0);
        end

        // Random exact-mode traffic with random backpressure
        acc    = 0;
        budget = 0;
        while (acc < 1000 && budget < 20000) begin
            drive($urandom_range(0, 3) != 0, 1'b1, TN'($urandom), TN'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
            step();
            if (acc_seen) acc++;
            budget++;
        end
        check("rand_exact_accepted", 64'(acc), 64'd1000);

        // Random mixed-mode traffic with operands of varied magnitude
        acc    = 0;
        budget = 0;
        while (acc < 300 && budget < 6000) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra(), ra());
            out_ready = $urandom_range(0, 3) != 0;
            step();
            if (acc_seen) acc++;
            budget++;
        end
        check("rand_mixed_accepted", 64'(acc), 64'd300);

        // Drain
        drive(1'b0, 1'b0, '0, '0);
        out_ready = 1'b1;
        drain = 0;
        while (exp_q.size() != 0 && drain < 20) begin
            step();
            drain++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        step();
        check("drain_idle", 64'(ov_seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
